// File: rtl/twod_mem_arb.sv
// Single-port controller for the 16x16 byte array: zero-sweep after reset or on
// clr_start, otherwise round-robin sharing of the RAM port between two requesters.
module twod_mem_arb #(
  parameter int DW = 8,
  parameter int RW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          busy,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [RW-1:0] r0_row,
  input  logic [CW-1:0] r0_col,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [RW-1:0] r1_row,
  input  logic [CW-1:0] r1_col,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [RW+CW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int AW   = RW + CW;
  localparam int NREQ = 2;

  typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic [NREQ-1:0] rvld_q, rvld_d;

  logic [NREQ-1:0]         req, we, gnt;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][DW-1:0] wdata;
  logic                    serve;

  assign req   = {r1_req, r0_req};
  assign we    = {r1_we, r0_we};
  assign addr  = {{r1_row, r1_col}, {r0_row, r0_col}};
  assign wdata = {r1_wdata, r0_wdata};

  // Reset overrides the registered state so outputs are quiet during rst.
  assign serve = (state_q == SERVE) && !rst;

  generate
    for (genvar n = 0; n < NREQ; n++) begin : g_lane
      localparam int OTH = NREQ - 1 - n;
      assign gnt[n]    = serve && req[n] && (!req[OTH] || (prio_q == 1'(n)));
      assign rvld_d[n] = gnt[n] && !we[n];
    end
  endgenerate

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cnt_q;
      end else begin
        for (int n = 0; n < NREQ; n++) begin
          if (gnt[n]) begin
            mem_en    = 1'b1;
            mem_we    = we[n];
            mem_addr  = addr[n];
            mem_wdata = wdata[n];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    case (state_q)
      CLEAR: begin
        // cnt wraps back to 0 naturally after the last address
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = SERVE;
      end
      default: begin
        if (gnt[0])      prio_d = 1'b1;
        else if (gnt[1]) prio_d = 1'b0;
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      rvld_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      rvld_q  <= rvld_d;
    end
  end

  assign busy      = rst || (state_q == CLEAR);
  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign r0_rvalid = rvld_q[0] && !rst;
  assign r1_rvalid = rvld_q[1] && !rst;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule
